muldiv_sched: RTL and testbench

Issue controller and PSX-accurate timing scheduler placed between the execute stage and the HI/LO multiply/divide unit. It accepts one muldiv-class instruction per cycle from execute and converts it into a registered single-cycle command strobe for the unit. It models R3000A multiply/divide latency so that MFHI/MFLO interlocks match real hardware, even when the unit finishes sooner. It stalls execute while an instruction cannot issue and returns MFHI/MFLO read data.

---
 rtl/muldiv_sched_if.sv | 39 +++
 rtl/muldiv_sched.sv | 108 ++++++++++
 tb/tb_muldiv_sched.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sched_if.sv
// Execute-side request/response and HI/LO unit command signals for muldiv_sched.
// master = execute stage plus the HI/LO unit, slave = the scheduler.
interface muldiv_sched_if;
  // Handshake: a request is taken in exactly the cycles where req_valid && req_ready.
  // req_ready is combinational. flush kills the current request, and execute holds the
  // request stable while stall is high. res_valid is a one-cycle pulse with res_data.
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        req_ready;
  logic        stall;
  logic        res_valid;
  logic [31:0] res_data;
  logic        rf_mult;
  logic        rf_multu;
  logic        rf_div;
  logic        rf_divu;
  logic        rf_mthi;
  logic        rf_mtlo;
  logic [31:0] exe_a;
  logic [31:0] exe_b;
  logic        muldiv_busy;
  logic [31:0] multi_hi;
  logic [31:0] multi_lo;

  modport master (
    output req_valid, req_op, req_a, req_b, flush, muldiv_busy, multi_hi, multi_lo,
    input  req_ready, stall, res_valid, res_data,
    input  rf_mult, rf_multu, rf_div, rf_divu, rf_mthi, rf_mtlo, exe_a, exe_b
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, muldiv_busy, multi_hi, multi_lo,
    output req_ready, stall, res_valid, res_data,
    output rf_mult, rf_multu, rf_div, rf_divu, rf_mthi, rf_mtlo, exe_a, exe_b
  );
endinterface

// File: rtl/muldiv_sched.sv
// Issue controller for the HI/LO multiply/divide unit with R3000A-accurate latency
// emulation so MFHI/MFLO interlock exactly as on real hardware.
module muldiv_sched #(
  parameter int MULT_FAST  = 6,
  parameter int MULT_MED   = 9,
  parameter int MULT_SLOW  = 13,
  parameter int DIV_CYCLES = 36,
  parameter int CNT_W      = 6
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_sched_if.slave bus
);

  localparam logic [2:0] OP_MFHI = 3'd6;

  logic [5:0]       cmd;       // one-hot strobe, bit index = req_op
  logic [5:0]       cmd_next;
  logic [31:0]      exe_a_q;
  logic [31:0]      exe_b_q;
  logic [31:0]      res_data_q;
  logic             res_valid_q;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] load_lat;
  logic             is_muldiv;
  logic             strobe_pend;
  logic             done;
  logic             accept;
  logic             fits_fast;
  logic             fits_med;

  always_comb begin
    is_muldiv   = !bus.req_op[2];
    strobe_pend = |cmd;
    done        = (lat_cnt == '0) && !bus.muldiv_busy && !strobe_pend;
    accept      = 1'b0;
    if (bus.req_valid && !bus.flush) begin
      // mul/div may restart while emulated timing is still running; HI/LO moves may not
      accept = is_muldiv ? (!bus.muldiv_busy && !strobe_pend) : done;
    end
    cmd_next = '0;
    if (accept && !(bus.req_op[2] && bus.req_op[1])) begin
      cmd_next = 6'b000001 << bus.req_op;
    end
  end

  // Early-out multiply timing depends on how many significant bits rs carries.
  always_comb begin
    if (bus.req_op[0]) begin
      fits_fast = ~|bus.req_a[31:11];
      fits_med  = ~|bus.req_a[31:20];
    end else begin
      fits_fast = (&bus.req_a[31:11]) | ~(|bus.req_a[31:11]);
      fits_med  = (&bus.req_a[31:20]) | ~(|bus.req_a[31:20]);
    end
    if (bus.req_op[1]) begin
      load_lat = CNT_W'(DIV_CYCLES);
    end else if (fits_fast) begin
      load_lat = CNT_W'(MULT_FAST);
    end else if (fits_med) begin
      load_lat = CNT_W'(MULT_MED);
    end else begin
      load_lat = CNT_W'(MULT_SLOW);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd         <= '0;
      exe_a_q     <= '0;
      exe_b_q     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      lat_cnt     <= '0;
    end else begin
      cmd         <= cmd_next;
      res_valid_q <= 1'b0;
      if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end
      if (accept) begin
        exe_a_q <= bus.req_a;
        exe_b_q <= bus.req_b;
        if (is_muldiv) begin
          lat_cnt <= load_lat;
        end
        if (bus.req_op[2] && bus.req_op[1]) begin
          res_data_q  <= (bus.req_op == OP_MFHI) ? bus.multi_hi : bus.multi_lo;
          res_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = accept;
  assign bus.stall     = bus.req_valid && !accept && !bus.flush;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.rf_mult   = cmd[0];
  assign bus.rf_multu  = cmd[1];
  assign bus.rf_div    = cmd[2];
  assign bus.rf_divu   = cmd[3];
  assign bus.rf_mthi   = cmd[4];
  assign bus.rf_mtlo   = cmd[5];
  assign bus.exe_a     = exe_a_q;
  assign bus.exe_b     = exe_b_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: behavioural HI/LO unit, cycle-deadline reference model,
// directed timing cases from the test plan and a randomized phase.
module tb_muldiv_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_sched_if bus ();

  muldiv_sched dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3;
  localparam logic [2:0] MTHI = 3'd4, MTLO = 3'd5, MFHI = 3'd6, MFLO = 3'd7;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat_ready = 0;
  int unit_lat_mul = 2;
  int unit_lat_div = 8;

  logic [5:0]  exp_rf;
  logic [31:0] exp_a, exp_b, exp_res, arch_hi, arch_lo;
  logic        exp_rv;
  logic [31:0] exp_q[$];

  logic [31:0] edge_vals[8] = '{32'h0000_07FF, 32'h0000_0800, 32'h000F_FFFF, 32'h0010_0000,
                                32'hFFFF_F800, 32'hFFFF_F7FF, 32'hFFF0_0000, 32'hFFEF_FFFF};

  // ---------------- arithmetic and timing rules ----------------
  function automatic logic [63:0] arith(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    sa = $signed(a);
    sb = $signed(b);
    qa = a;
    qb = b;
    case (op)
      MULT:  return sa * sb;
      MULTU: return {32'd0, a} * {32'd0, b};
      DIV: begin
        if (b == 32'd0) return {a, (qa < 0) ? 32'd1 : 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(qa % qb), 32'(qa / qb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a);
    int s;
    s = $signed(a);
    if (op[1]) return 36;
    if (op == MULT) begin
      if (s >= -2048 && s < 2048) return 6;
      if (s >= -1048576 && s < 1048576) return 9;
      return 13;
    end
    if (a < 32'd2048) return 6;
    if (a < 32'd1048576) return 9;
    return 13;
  endfunction

  function automatic logic [31:0] pick_a();
    if ($urandom_range(0, 2) == 0) return edge_vals[$urandom_range(0, 7)];
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 4095));
    return $urandom;
  endfunction

  // ---------------- behavioural HI/LO unit ----------------
  logic [31:0] u_hi, u_lo, p_hi, p_lo;
  int          u_cnt;
  logic [5:0]  strobes;
  logic [2:0]  u_op;
  logic [63:0] u_r;
  int          u_l;

  assign strobes = {bus.rf_mtlo, bus.rf_mthi, bus.rf_divu, bus.rf_div, bus.rf_multu, bus.rf_mult};
  assign bus.muldiv_busy = (|strobes) || (u_cnt != 0);
  assign bus.multi_hi = u_hi;
  assign bus.multi_lo = u_lo;

  always @(posedge clk) begin
    if (!rst_n) begin
      u_hi  <= '0;
      u_lo  <= '0;
      u_cnt <= 0;
    end else begin
      if (u_cnt != 0) begin
        u_cnt <= u_cnt - 1;
        if (u_cnt == 1) begin
          u_hi <= p_hi;
          u_lo <= p_lo;
        end
      end
      if (|strobes[3:0]) begin
        u_op = bus.rf_mult ? MULT : bus.rf_multu ? MULTU : bus.rf_div ? DIV : DIVU;
        u_r  = arith(u_op, bus.exe_a, bus.exe_b);
        u_l  = u_op[1] ? unit_lat_div : unit_lat_mul;
        if (u_l == 0) begin
          u_hi <= u_r[63:32];
          u_lo <= u_r[31:0];
        end else begin
          p_hi  <= u_r[63:32];
          p_lo  <= u_r[31:0];
          u_cnt <= u_l;
        end
      end
      if (bus.rf_mthi) u_hi <= bus.exe_a;
      if (bus.rf_mtlo) u_lo <= bus.exe_a;
    end
  end

  // ---------------- checking and driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    chk("rst_strobes", 32'(strobes), 32'd0);
    chk("rst_exe_a", bus.exe_a, 32'd0);
    chk("rst_exe_b", bus.exe_b, 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data", bus.res_data, 32'd0);
    exp_rf = '0;
    exp_a = '0;
    exp_b = '0;
    exp_res = '0;
    exp_rv = 1'b0;
    arch_hi = '0;
    arch_lo = '0;
    lat_ready = 0;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive a request, check the combinational handshake, then the registered outputs.
  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, output logic acc);
    logic busy_now, strobe_now, done_now, rdy;
    logic [63:0] r;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.flush = fl;
    #1;
    busy_now = bus.muldiv_busy;
    strobe_now = (exp_rf != '0);
    done_now = (cyc >= lat_ready) && !busy_now && !strobe_now;
    rdy = v && !fl && ((op < 3'd4) ? (!busy_now && !strobe_now) : done_now);
    chk("req_ready", 32'(bus.req_ready), 32'(rdy));
    chk("stall", 32'(bus.stall), 32'(v && !rdy && !fl));
    acc = bus.req_ready;
    exp_rf = '0;
    exp_rv = 1'b0;
    if (rdy) begin
      exp_a = a;
      exp_b = b;
      case (op)
        MULT, MULTU, DIV, DIVU: begin
          exp_rf = 6'b000001 << op;
          lat_ready = cyc + 1 + lat_of(op, a);
          r = arith(op, a, b);
          arch_hi = r[63:32];
          arch_lo = r[31:0];
        end
        MTHI: begin
          exp_rf = 6'b010000;
          arch_hi = a;
        end
        MTLO: begin
          exp_rf = 6'b100000;
          arch_lo = a;
        end
        MFHI: begin
          exp_q.push_back(arch_hi);
          exp_rv = 1'b1;
        end
        default: begin
          exp_q.push_back(arch_lo);
          exp_rv = 1'b1;
        end
      endcase
    end
    @(posedge clk);
    cyc++;
    #1;
    if (exp_rv) exp_res = exp_q.pop_front();
    chk("strobes", 32'(strobes), 32'(exp_rf));
    chk("exe_a", bus.exe_a, exp_a);
    chk("exe_b", bus.exe_b, exp_b);
    chk("res_valid", 32'(bus.res_valid), 32'(exp_rv));
    chk("res_data", bus.res_data, exp_res);
  endtask

  task automatic hold(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input int budget, output int waited);
    logic acc;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      step(1'b1, op, a, b, 1'b0, acc);
      if (acc) return;
      waited++;
    end
    total++;
    bad++;
    $error("FAIL hold_timeout op=%0d observed=no_accept_after_%0d expected=accept", op, budget);
  endtask

  task automatic lat_check(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] mf, input int exp_wait, input logic [31:0] exp_val,
                           input string tag);
    logic acc;
    int w;
    step(1'b1, op, a, b, 1'b0, acc);
    chk({tag, "_issue"}, 32'(acc), 32'd1);
    hold(mf, 32'd0, 32'd0, 80, w);
    chk({tag, "_wait"}, 32'(w), 32'(exp_wait));
    chk({tag, "_data"}, bus.res_data, exp_val);
  endtask

  // ---------------- directed sequence then random ----------------
  logic [2:0]  t_op[7] = '{MULT, MULT, MULT, MULT, MULT, MULT, MULTU};
  logic [31:0] t_a[7] = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'hFFF0_0000,
                          32'hFFEF_FFFF, 32'h0000_0800};
  int          t_w[7] = '{6, 9, 6, 9, 9, 13, 9};

  initial begin
    logic acc, v, fl;
    logic [2:0] op;
    logic [31:0] a, b;
    logic [63:0] r;
    int w;

    bus.req_valid = 1'b0;
    bus.req_op = 3'd0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.flush = 1'b0;
    do_reset();

    lat_check(MULT, 32'd5, 32'd7, MFLO, 6, 32'd35, "mult_5x7");
    chk("mult_5x7_rv", 32'(bus.res_valid), 32'd1);
    lat_check(MULTU, 32'h0008_0000, 32'd2, MFHI, 9, 32'd0, "multu_med");
    lat_check(MULTU, 32'h8000_0000, 32'd2, MFHI, 13, 32'd1, "multu_slow");
    lat_check(DIVU, 32'd100, 32'd7, MFLO, 36, 32'd14, "divu_lo");
    hold(MFHI, 32'd0, 32'd0, 5, w);
    chk("divu_hi_wait", 32'(w), 32'd0);
    chk("divu_hi_data", bus.res_data, 32'd2);
    lat_check(MTHI, 32'hDEAD_BEEF, 32'd0, MFHI, 1, 32'hDEAD_BEEF, "mthi_mfhi");

    for (int i = 0; i < 7; i++) begin
      r = arith(t_op[i], t_a[i], 32'd3);
      lat_check(t_op[i], t_a[i], 32'd3, MFLO, t_w[i], r[31:0], $sformatf("bound%0d", i));
    end

    // unit slower than the emulated count; a DIV arriving behind a MULT restarts timing
    unit_lat_mul = 10;
    lat_check(MULT, 32'd3, 32'hFFFF_FFFC, MFLO, 11, 32'hFFFF_FFF4, "slow_unit");
    step(1'b1, MULT, 32'd5, 32'd7, 1'b0, acc);
    chk("m_then_d_issue", 32'(acc), 32'd1);
    hold(DIV, 32'hFFFF_FF9C, 32'd7, 40, w);
    chk("m_then_d_wait", 32'(w), 32'd11);
    hold(MFLO, 32'd0, 32'd0, 60, w);
    chk("div_reload_wait", 32'(w), 32'd36);
    chk("div_lo_data", bus.res_data, 32'hFFFF_FFF2);
    hold(MFHI, 32'd0, 32'd0, 5, w);
    chk("div_hi_data", bus.res_data, 32'hFFFF_FFFE);
    unit_lat_mul = 2;

    // flush on the only eligible cycle of an MFLO
    step(1'b1, MULT, 32'd5, 32'd7, 1'b0, acc);
    for (int i = 0; i < 6; i++) step(1'b1, MFLO, 32'd0, 32'd0, 1'b0, acc);
    step(1'b1, MFLO, 32'd0, 32'd0, 1'b1, acc);
    chk("flush_acc", 32'(acc), 32'd0);
    chk("flush_rv", 32'(bus.res_valid), 32'd0);
    lat_check(MULT, 32'd2, 32'd2, MFLO, 6, 32'd4, "after_flush");

    for (int t = 0; t < 80; t++) begin
      op = 3'($urandom_range(0, 7));
      a = pick_a();
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : (($urandom_range(0, 3) == 0) ? pick_a() : $urandom);
      unit_lat_mul = $urandom_range(0, 16);
      unit_lat_div = $urandom_range(0, 44);
      for (int k = 0; k < 60; k++) begin
        fl = ($urandom_range(0, 15) == 0);
        v = ($urandom_range(0, 7) != 0);
        step(v, op, a, b, fl, acc);
        if (acc) break;
      end
    end
    unit_lat_div = 8;

    // reset in the middle of a divide
    hold(MTLO, 32'h0000_1234, 32'd0, 80, w);
    hold(MFLO, 32'd0, 32'd0, 10, w);
    chk("pre_rst_data", bus.res_data, 32'h0000_1234);
    hold(DIV, 32'd1000, 32'd3, 80, w);
    for (int i = 0; i < 3; i++) step(1'b0, MULT, 32'd0, 32'd0, 1'b0, acc);
    do_reset();
    hold(MFHI, 32'd0, 32'd0, 5, w);
    chk("post_rst_wait", 32'(w), 32'd0);
    chk("post_rst_hi", bus.res_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
